// File: rtl/thread_pc_sequencer_if.sv
// Fetch-side bundle of the PC sequencer: branch-folding feedback and host PC
// overwrite in, issued PC/thread out.
interface thread_pc_sequencer_if #(
   parameter int PC_WIDTH          = 10,
   parameter int THREAD_ADDR_WIDTH = 3
) ();
   logic [PC_WIDTH-1:0]          branch_destination;
   logic                         jump;
   logic                         cancel;
   logic                         pc_wr_en;
   logic [THREAD_ADDR_WIDTH-1:0] pc_wr_thread;
   logic [PC_WIDTH-1:0]          pc_wr_data;
   logic [PC_WIDTH-1:0]          PC;
   logic [THREAD_ADDR_WIDTH-1:0] thread_id;
   logic                         issue_valid;

   modport master (
      input  branch_destination, jump, cancel, pc_wr_en, pc_wr_thread, pc_wr_data,
      output PC, thread_id, issue_valid
   );

   modport slave (
      output branch_destination, jump, cancel, pc_wr_en, pc_wr_thread, pc_wr_data,
      input  PC, thread_id, issue_valid
   );
endinterface

// File: rtl/thread_pc_sequencer.sv
// Barrel-order per-thread PC sequencer: one thread issued per cycle, its next PC
// written back FEEDBACK_LATENCY cycles later from the branch folding result.
module thread_pc_sequencer #(
   parameter int PC_WIDTH          = 10,
   parameter int THREAD_COUNT      = 8,
   parameter int THREAD_ADDR_WIDTH = 3,
   parameter int INITIAL_THREAD    = 0,
   parameter int START_PC          = 0,
   parameter int FEEDBACK_LATENCY  = 4
) (
   input logic                    clock,
   input logic                    reset_n,
   thread_pc_sequencer_if.master  bus
);

   if (THREAD_COUNT < 2 || FEEDBACK_LATENCY < 1 || FEEDBACK_LATENCY > THREAD_COUNT - 1 ||
       THREAD_ADDR_WIDTH != $clog2(THREAD_COUNT) || INITIAL_THREAD >= THREAD_COUNT) begin : g_bad_params
      $error("thread_pc_sequencer: illegal THREAD_COUNT/FEEDBACK_LATENCY/INITIAL_THREAD");
   end

   localparam logic [PC_WIDTH-1:0]          RESET_PC     = PC_WIDTH'(START_PC);
   localparam logic [THREAD_ADDR_WIDTH-1:0] RESET_THREAD = THREAD_ADDR_WIDTH'(INITIAL_THREAD);
   localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_THREAD  = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);
   localparam logic [THREAD_ADDR_WIDTH:0]   THREAD_LIMIT = (THREAD_ADDR_WIDTH + 1)'(THREAD_COUNT);

   logic [PC_WIDTH-1:0]          pc_mem_q [THREAD_COUNT];
   logic [PC_WIDTH-1:0]          pc_mem_d [THREAD_COUNT];
   logic [THREAD_ADDR_WIDTH-1:0] slot_q, slot_d;
   logic [PC_WIDTH-1:0]          pc_q;
   logic [THREAD_ADDR_WIDTH-1:0] thread_q;
   logic                         valid_q;

   // Stage 0 captures the issue slot alongside the outputs; the last stage is the write-back slot.
   logic [THREAD_ADDR_WIDTH-1:0] dl_thread_q [FEEDBACK_LATENCY];
   logic [PC_WIDTH-1:0]          dl_pc_q     [FEEDBACK_LATENCY];
   logic                         dl_valid_q  [FEEDBACK_LATENCY];

   logic [THREAD_ADDR_WIDTH-1:0] wb_thread_s;
   logic [PC_WIDTH-1:0]          wb_pc_s;
   logic                         wb_valid_s;
   logic [PC_WIDTH-1:0]          wb_next_s;
   logic                         host_hit_s;

   assign wb_thread_s = dl_thread_q[FEEDBACK_LATENCY-1];
   assign wb_pc_s     = dl_pc_q[FEEDBACK_LATENCY-1];
   assign wb_valid_s  = dl_valid_q[FEEDBACK_LATENCY-1];
   assign host_hit_s  = bus.pc_wr_en && ({1'b0, bus.pc_wr_thread} < THREAD_LIMIT);

   // Round-robin slot advance.
   always_comb begin
      slot_d = slot_q;
      if (slot_q == LAST_THREAD) begin
         slot_d = '0;
      end else begin
         slot_d = slot_q + THREAD_ADDR_WIDTH'(1);
      end
   end

   // Branch result for the write-back slot: jump beats cancel, default is sequential.
   always_comb begin
      wb_next_s = wb_pc_s;
      if (bus.jump) begin
         wb_next_s = bus.branch_destination;
      end else if (bus.cancel) begin
         wb_next_s = wb_pc_s;
      end else begin
         wb_next_s = wb_pc_s + PC_WIDTH'(1);
      end
   end

   // PC table update; a host write to the write-back thread takes precedence.
   always_comb begin
      for (int t = 0; t < THREAD_COUNT; t++) begin
         pc_mem_d[t] = pc_mem_q[t];
         if (host_hit_s && bus.pc_wr_thread == THREAD_ADDR_WIDTH'(t)) begin
            pc_mem_d[t] = bus.pc_wr_data;
         end else if (wb_valid_s && wb_thread_s == THREAD_ADDR_WIDTH'(t)) begin
            pc_mem_d[t] = wb_next_s;
         end else begin
            pc_mem_d[t] = pc_mem_q[t];
         end
      end
   end

   // All sequencer state: PC table, slot counter, issue outputs and feedback delay line.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int t = 0; t < THREAD_COUNT; t++) begin
            pc_mem_q[t] <= RESET_PC;
         end
         slot_q   <= RESET_THREAD;
         pc_q     <= RESET_PC;
         thread_q <= RESET_THREAD;
         valid_q  <= 1'b0;
         for (int j = 0; j < FEEDBACK_LATENCY; j++) begin
            dl_thread_q[j] <= '0;
            dl_pc_q[j]     <= '0;
            dl_valid_q[j]  <= 1'b0;
         end
      end else begin
         pc_mem_q       <= pc_mem_d;
         slot_q         <= slot_d;
         pc_q           <= pc_mem_q[slot_q];
         thread_q       <= slot_q;
         valid_q        <= 1'b1;
         dl_thread_q[0] <= slot_q;
         dl_pc_q[0]     <= pc_mem_q[slot_q];
         dl_valid_q[0]  <= 1'b1;
         for (int j = 1; j < FEEDBACK_LATENCY; j++) begin
            dl_thread_q[j] <= dl_thread_q[j-1];
            dl_pc_q[j]     <= dl_pc_q[j-1];
            dl_valid_q[j]  <= dl_valid_q[j-1];
         end
      end
   end

   assign bus.PC          = pc_q;
   assign bus.thread_id   = thread_q;
   assign bus.issue_valid = valid_q;

endmodule

// File: tb/tb_thread_pc_sequencer.sv
// Directed bench for thread_pc_sequencer (PC_WIDTH=10, 8 threads, latency 4).
module tb_thread_pc_sequencer;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   thread_pc_sequencer_if #(.PC_WIDTH(10), .THREAD_ADDR_WIDTH(3)) bus ();

   thread_pc_sequencer #(
      .PC_WIDTH(10), .THREAD_COUNT(8), .THREAD_ADDR_WIDTH(3),
      .INITIAL_THREAD(0), .START_PC(0), .FEEDBACK_LATENCY(4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic j, input logic c, input logic [9:0] dest,
                        input logic we, input logic [2:0] wt, input logic [9:0] wd);
      bus.jump               = j;
      bus.cancel             = c;
      bus.branch_destination = dest;
      bus.pc_wr_en           = we;
      bus.pc_wr_thread       = wt;
      bus.pc_wr_data         = wd;
   endtask

   // Issue n after reset: thread (n-1)%8, PC (n-1)/8 unless redirected below.
   function automatic logic [9:0] exp_pc(input int n);
      case (n)
         30:      return 10'h002;  // thread 5 replayed
         36:      return 10'h155;  // thread 3 jump
         38:      return 10'h2A0;  // thread 5 jump+cancel
         39:      return 10'h3FF;  // thread 6 host write
         43:      return 10'h040;  // thread 2 host beats jump
         44:      return 10'h156;
         46:      return 10'h2A1;
         47:      return 10'h000;  // 0x3FF wraps
         51:      return 10'h041;
         52:      return 10'h157;
         default: return 10'((n - 1) / 8);
      endcase
   endfunction

   task automatic check_issue(input int n);
      check($sformatf("thread@%0d", n), 32'(bus.thread_id), 32'((n - 1) % 8));
      check($sformatf("pc@%0d", n), 32'(bus.PC), 32'(exp_pc(n)));
      check($sformatf("valid@%0d", n), 32'(bus.issue_valid), 32'd1);
   endtask

   // Straight run from reset; optionally hold jump through the first four edges.
   task automatic run_plain(input int count, input logic hold_jump);
      for (int n = 1; n <= count; n++) begin
         tick();
         check_issue(n);
         if (hold_jump && n == 4) drive(1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 10'h000);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 10'h000);
      tick();
      tick();
      check("rst_pc", 32'(bus.PC), 32'd0);
      check("rst_thread", 32'(bus.thread_id), 32'd0);
      check("rst_valid", 32'(bus.issue_valid), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      run_plain(24, 1'b0);

      for (int n = 25; n <= 52; n++) begin
         tick();
         check_issue(n);
         case (n)
            25:      drive(1'b0, 1'b1, 10'h000, 1'b0, 3'd0, 10'h000);  // cancel thread 5
            31:      drive(1'b1, 1'b0, 10'h155, 1'b0, 3'd0, 10'h000);  // jump thread 3
            33:      drive(1'b1, 1'b1, 10'h2A0, 1'b0, 3'd0, 10'h000);  // jump+cancel thread 5
            35:      drive(1'b0, 1'b0, 10'h000, 1'b1, 3'd6, 10'h3FF);  // host thread 6, wb thread 7
            38:      drive(1'b1, 1'b0, 10'h100, 1'b1, 3'd2, 10'h040);  // host and wb on thread 2
            40:      drive(1'b0, 1'b0, 10'h000, 1'b1, 3'd0, 10'h123);  // host write on issue edge
            default: drive(1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 10'h000);
         endcase
      end

      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_pc", 32'(bus.PC), 32'd0);
      check("async_rst_thread", 32'(bus.thread_id), 32'd0);
      check("async_rst_valid", 32'(bus.issue_valid), 32'd0);
      tick();
      check("held_rst_valid", 32'(bus.issue_valid), 32'd0);
      check("held_rst_pc", 32'(bus.PC), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      drive(1'b1, 1'b0, 10'h2AA, 1'b0, 3'd0, 10'h000);
      run_plain(24, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
